// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The master drives the parallel word; the slave is the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sout_first, sout_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sout_first, sout_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out transmitter with first/last strobes.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  piso_serializer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  // state | meaning
  // IDLE  | no frame in progress, ready for a word
  // SHIFT | data bits on sout, cnt = bits left after the one shown
  // PARITY| parity bit on sout (PISO_PARITY_EN only)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_sout, w_sout_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_first, w_first_nxt;
  logic             r_last, w_last_nxt;
  logic             w_last_bit;
  logic             w_xfer;
`ifdef PISO_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

`ifdef PISO_PARITY_EN
  assign w_last_bit = (r_state == PARITY);
`else
  assign w_last_bit = (r_state == SHIFT) && (r_cnt == '0);
`endif

  assign bus.din_ready  = !reset && ((r_state == IDLE) || w_last_bit);
  assign w_xfer         = bus.din_valid && bus.din_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_valid;
  assign bus.sout_first = r_first;
  assign bus.sout_last  = r_last;
  assign bus.busy       = r_valid;

  // sreg keeps only the bits not yet presented; the MSB goes straight to sout.
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    w_sout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_first_nxt = 1'b0;
    w_last_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (w_xfer) begin
      w_state_nxt = SHIFT;
      w_sreg_nxt  = {bus.din[WIDTH-2:0], 1'b0};
      w_cnt_nxt   = CW'(WIDTH - 1);
      w_sout_nxt  = bus.din[WIDTH-1];
      w_valid_nxt = 1'b1;
      w_first_nxt = 1'b1;
`ifdef PISO_PARITY_EN
      w_par_nxt   = ^bus.din;
`endif
    end else begin
      unique case (r_state)
        SHIFT: begin
          if (r_cnt != '0) begin
            w_sreg_nxt  = {r_sreg[WIDTH-2:0], 1'b0};
            w_cnt_nxt   = r_cnt - CW'(1);
            w_sout_nxt  = r_sreg[WIDTH-1];
            w_valid_nxt = 1'b1;
`ifndef PISO_PARITY_EN
            w_last_nxt  = (r_cnt == CW'(1));
`endif
          end else begin
`ifdef PISO_PARITY_EN
            w_state_nxt = PARITY;
            w_sout_nxt  = r_par;
            w_valid_nxt = 1'b1;
            w_last_nxt  = 1'b1;
`else
            w_state_nxt = IDLE;
`endif
          end
        end
        PARITY:  w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sout  <= w_sout_nxt;
      r_valid <= w_valid_nxt;
      r_first <= w_first_nxt;
      r_last  <= w_last_nxt;
`ifdef PISO_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, with first and last framing strobes. It is the transmit-side counterpart to the design's serial-capture register chain and sits between a parallel datapath and a single-wire serial link. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high; clock clk.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle. A transfer happens on a rising edge where din_valid && din_ready.
- sout  output  1  serial data bit, registered.
- sout_valid  output  1  sout carries a frame bit this cycle, registered.
- sout_first  output  1  sout is the first bit (MSB) of a frame, registered.
- sout_last  output  1  sout is the final bit of a frame, registered.
- busy  output  1  a frame is in progress (equal to sout_valid).

## Operation
- Internal state:
  - FSM states: IDLE, SHIFT, and PARITY (only with the configuration macro).
  - shift register sreg[WIDTH-1:0].
  - bit counter cnt, width clog2(WIDTH); wraps only via reload.
- IDLE:
  - din_ready = 1.
  - On a transfer: sreg <= din, cnt <= WIDTH-1, go to SHIFT.
  - The registered outputs present din[WIDTH-1] with sout_first = 1 in the next cycle.
- SHIFT:
  - Each cycle, sout shows the current MSB of sreg, then sreg shifts left by 1 (zero fill) and cnt decrements.
  - sout_last = 1 when cnt == 0 and no parity bit follows.
- din_ready is combinational:
  - 1 in IDLE.
  - 1 in the final-bit cycle of a frame (SHIFT with cnt==0 without parity, or PARITY with parity).
  - 0 otherwise, and 0 while reset is high.
- Back-to-back: a transfer during the final-bit cycle reloads sreg and cnt. The next cycle shows the new MSB with sout_first = 1 and sout_valid stays high. With no transfer in the final-bit cycle, the FSM returns to IDLE and sout_valid drops the following cycle.
- When din_valid is high while din_ready is 0, the word is not taken. The upstream must hold din stable until the transfer.
- Reset values: FSM = IDLE, sreg = 0, cnt = 0, sout = 0, sout_valid = 0, sout_first = 0, sout_last = 0, busy = 0.
- Reset mid-frame aborts the frame and discards the word. All outputs read 0 in the cycle after the reset edge. din_ready is 1 in the first cycle with reset low.
- If reset and a transfer coincide on the same edge, reset wins and the word is not accepted.

## Timing
- Latency: the MSB appears on sout exactly 1 cycle after the transfer edge.
- Frame length: WIDTH cycles, or WIDTH+1 with parity.
- sout_first and sout_last are each high for exactly 1 cycle per frame. They are never high in the same cycle because WIDTH is at least 2.
- Sustained throughput: 1 word per WIDTH (or WIDTH+1) cycles with zero gap.
- All outputs except din_ready are registered. There is no combinational path from din or din_valid to sout.

## Configuration
- PISO_PARITY_EN defined:
  - Adds the PARITY state, entered after the LSB.
  - sout = even parity, the XOR of the accepted word captured at load; sout_last moves to this bit.
  - Frame length becomes WIDTH+1.
  - The final-bit/din_ready rule applies to the PARITY cycle.
- PISO_PARITY_EN undefined:
  - No PARITY state and no parity logic.
  - Frame length is WIDTH; sout_last is on the LSB.

## Test plan
- Single word, WIDTH=8, din=8'hA5 pulsed valid 1 cycle from IDLE -> sout = 1,0,1,0,0,1,0,1 over the next 8 cycles; sout_first on cycle 1, sout_last on cycle 8; sout_valid = 0 on cycle 9; din_ready low for cycles 1-7.
- Back-to-back: din_valid held high with 8'hFF, then 8'h00 switched on the handshake -> 16 contiguous sout_valid cycles, 8 ones then 8 zeros; sout_first on cycles 1 and 9; sout_last on cycles 8 and 16.
- Stall: din_valid asserted with 8'h3C on cycle 3 of a frame -> not accepted until the cycle-8 handshake; 8'h3C starts on cycle 9 with no gap.
- Reset mid-frame: reset for 1 cycle after 3 bits of 8'hF0 -> the next cycle has all outputs 0 and the FSM in IDLE; din_ready = 1; a new word 8'h81 transmits cleanly.
- Reset coincident with transfer: din_valid = 1 and reset = 1 on the same edge -> no frame starts; sout_valid stays 0.
- With PISO_PARITY_EN: din=8'h07 -> 8 data bits then parity bit 1, with sout_last on cycle 9; din=8'h03 -> parity bit 0.
